// File: rtl/udp_parser.sv
// Streaming Ethernet/IPv4/UDP parser: input byte FIFO -> header-stripping FSM -> payload FIFO.
// FIFO entries are {sof, eof, data[7:0]}; the output FIFO is first-word-fall-through.
module udp_parser #(
  parameter int unsigned IN_FIFO_DEPTH  = 16,
  parameter int unsigned OUT_FIFO_DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_din,
  input  logic       in_wr_en,
  input  logic       in_wr_sof,
  input  logic       in_wr_eof,
  output logic       in_full,
  input  logic       out_rd_en,
  output logic       out_rd_sof,
  output logic       out_rd_eof,
  output logic [7:0] out_dout,
  output logic       out_empty
);

  localparam int unsigned IAW = $clog2(IN_FIFO_DEPTH);
  localparam int unsigned OAW = $clog2(OUT_FIFO_DEPTH);
  localparam logic [IAW:0] InOne  = 1;
  localparam logic [OAW:0] OutOne = 1;

  typedef enum logic [2:0] {StEth, StIp, StUdp, StPayload, StDrop} state_e;

  // Input FIFO
  logic [9:0]   in_mem [IN_FIFO_DEPTH];
  logic [IAW:0] in_wptr_q, in_rptr_q;
  logic         in_empty, in_push, in_pop;
  logic [9:0]   in_head;

  assign in_empty = (in_wptr_q == in_rptr_q);
  assign in_full  = (in_wptr_q[IAW] != in_rptr_q[IAW]) &&
                    (in_wptr_q[IAW-1:0] == in_rptr_q[IAW-1:0]);
  assign in_push  = in_wr_en && !in_full;
  assign in_head  = in_mem[in_rptr_q[IAW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      in_wptr_q <= '0;
      in_rptr_q <= '0;
    end else begin
      if (in_push) in_wptr_q <= in_wptr_q + InOne;
      if (in_pop)  in_rptr_q <= in_rptr_q + InOne;
    end
  end

  always_ff @(posedge clock) begin
    if (in_push) in_mem[in_wptr_q[IAW-1:0]] <= {in_wr_sof, in_wr_eof, in_din};
  end

  // Output FIFO
  logic [9:0]   out_mem [OUT_FIFO_DEPTH];
  logic [OAW:0] out_wptr_q, out_rptr_q;
  logic         out_full, out_push, out_pop;
  logic [9:0]   out_wdata, out_head;

  assign out_empty = (out_wptr_q == out_rptr_q);
  assign out_full  = (out_wptr_q[OAW] != out_rptr_q[OAW]) &&
                     (out_wptr_q[OAW-1:0] == out_rptr_q[OAW-1:0]);
  assign out_pop   = out_rd_en && !out_empty;
  assign out_head  = out_mem[out_rptr_q[OAW-1:0]];

  // Head is masked while empty so the outputs read zero after reset.
  assign out_dout   = out_empty ? 8'd0 : out_head[7:0];
  assign out_rd_sof = !out_empty && out_head[9];
  assign out_rd_eof = !out_empty && out_head[8];

  always_ff @(posedge clock) begin
    if (reset) begin
      out_wptr_q <= '0;
      out_rptr_q <= '0;
    end else begin
      if (out_push) out_wptr_q <= out_wptr_q + OutOne;
      if (out_pop)  out_rptr_q <= out_rptr_q + OutOne;
    end
  end

  always_ff @(posedge clock) begin
    if (out_push) out_mem[out_wptr_q[OAW-1:0]] <= out_wdata;
  end

  // Parser FSM
  state_e      state_q, state_d, cur_state;
  logic [15:0] cnt_q, cnt_d, cur_cnt;
  logic [15:0] plen_q, plen_d;
  logic [7:0]  hold_q, hold_d;
  logic [3:0]  ihl_q, ihl_d;
  logic        b_sof, b_eof;
  logic [7:0]  b;

  assign b_sof = in_head[9];
  assign b_eof = in_head[8];
  assign b     = in_head[7:0];

  // A sof byte always restarts parsing at Ethernet byte 0.
  assign cur_state = b_sof ? StEth : state_q;
  assign cur_cnt   = b_sof ? 16'd0 : cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StEth;
      cnt_q   <= '0;
      plen_q  <= '0;
      hold_q  <= '0;
      ihl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      plen_q  <= plen_d;
      hold_q  <= hold_d;
      ihl_q   <= ihl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    plen_d  = plen_q;
    hold_d  = hold_q;
    ihl_d   = ihl_q;
    if (in_pop) begin
      state_d = cur_state;
      cnt_d   = cur_cnt + 16'd1;
      unique case (cur_state)
        StEth: begin
          if (cur_cnt == 16'd12) hold_d = b;
          if (cur_cnt == 16'd13) begin
            cnt_d   = '0;
            state_d = ({hold_q, b} == 16'h0800) ? StIp : StDrop;
          end
        end
        StIp: begin
          if (cur_cnt == 16'd0) begin
            ihl_d = b[3:0];
            if (b[7:4] != 4'd4 || b[3:0] < 4'd5) state_d = StDrop;
          end else if (cur_cnt == 16'd9) begin
            if (b != 8'h11) state_d = StDrop;
          end else if (cur_cnt == {10'd0, ihl_q, 2'b00} - 16'd1) begin
            cnt_d   = '0;
            state_d = StUdp;
          end
        end
        StUdp: begin
          if (cur_cnt == 16'd4) hold_d = b;
          if (cur_cnt == 16'd5) plen_d = {hold_q, b};
          if (cur_cnt == 16'd7) begin
            cnt_d = '0;
            if (plen_q <= 16'd8) begin
              state_d = StDrop;
            end else begin
              plen_d  = plen_q - 16'd8;
              state_d = StPayload;
            end
          end
        end
        StPayload: begin
          if (cur_cnt == plen_q - 16'd1) state_d = StDrop;
        end
        StDrop: ;
        default: state_d = StEth;
      endcase
      if (b_eof) begin
        state_d = StEth;
        cnt_d   = '0;
      end
    end
  end

  // Payload bytes stall when the output FIFO is full; header bytes never do.
  always_comb begin
    in_pop    = !in_empty && !(state_q == StPayload && out_full);
    out_push  = in_pop && (cur_state == StPayload);
    out_wdata = {(cur_cnt == 16'd0), (cur_cnt == plen_q - 16'd1) || b_eof, b};
  end

endmodule

// File: tb/tb_udp_parser.sv
// Randomized bench for udp_parser: a frame-level reference model fills a scoreboard queue
// that an independent monitor drains as the consumer pops payload bytes.
module tb_udp_parser;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_din = '0;
  logic       in_wr_en = 1'b0, in_wr_sof = 1'b0, in_wr_eof = 1'b0;
  logic       in_full;
  logic       out_rd_en = 1'b0;
  logic       out_rd_sof, out_rd_eof, out_empty;
  logic [7:0] out_dout;

  always #5 clock = ~clock;

  udp_parser #(.IN_FIFO_DEPTH(16), .OUT_FIFO_DEPTH(16)) dut (
    .clock(clock), .reset(reset),
    .in_din(in_din), .in_wr_en(in_wr_en), .in_wr_sof(in_wr_sof), .in_wr_eof(in_wr_eof),
    .in_full(in_full),
    .out_rd_en(out_rd_en), .out_rd_sof(out_rd_sof), .out_rd_eof(out_rd_eof),
    .out_dout(out_dout), .out_empty(out_empty)
  );

  int         checks = 0;
  int         errors = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_e;
  logic [7:0] frm[$];
  bit         cons_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected payload of one frame, derived straight from its byte layout.
  function automatic void model();
    int n, ihl, off, ulen, plen, cnt;
    n = frm.size();
    if (n < 15) return;
    if ({frm[12], frm[13]} != 16'h0800) return;
    if (frm[14][7:4] != 4'd4 || frm[14][3:0] < 4'd5) return;
    if (n < 24 || frm[23] != 8'h11) return;
    ihl = int'(frm[14][3:0]);
    off = 14 + ihl * 4 + 8;
    if (n <= off) return;
    ulen = int'({frm[off-4], frm[off-3]});
    if (ulen <= 8) return;
    plen = ulen - 8;
    cnt  = (n - off < plen) ? n - off : plen;
    for (int i = 0; i < cnt; i++) exp_q.push_back({i == 0, i == cnt - 1, frm[off+i]});
  endfunction

  function automatic void build(input logic [15:0] etype, input logic [7:0] vihl,
                                input logic [7:0] proto, input logic [15:0] ulen,
                                input int body);
    int ihl;
    frm.delete();
    for (int i = 0; i < 12; i++) frm.push_back(8'($urandom));
    frm.push_back(etype[15:8]);
    frm.push_back(etype[7:0]);
    ihl = (vihl[3:0] < 4'd5) ? 5 : int'(vihl[3:0]);
    for (int i = 0; i < ihl * 4; i++)
      frm.push_back((i == 0) ? vihl : (i == 9) ? proto : 8'($urandom));
    for (int i = 0; i < 4; i++) frm.push_back(8'($urandom));
    frm.push_back(ulen[15:8]);
    frm.push_back(ulen[7:0]);
    for (int i = 0; i < 2 + body; i++) frm.push_back(8'($urandom));
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
    int t;
    t = 0;
    in_din = d; in_wr_sof = s; in_wr_eof = e; in_wr_en = 1'b1;
    forever begin
      @(negedge clock);
      if (!in_full) break;
      t++;
      if (t > 3000) begin
        checks++; errors++;
        $display("FAIL writer_stall: in_full stuck at 1, required 0 within 3000 cycles");
        break;
      end
    end
    @(posedge clock); #1;
    in_wr_en = 1'b0;
  endtask

  task automatic send_frame(input bit use_model);
    if (use_model) model();
    for (int i = 0; i < frm.size(); i++) send_byte(frm[i], i == 0, i == frm.size() - 1);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    repeat (20) @(posedge clock);
    while ((exp_q.size() != 0 || !out_empty) && t < 5000) begin
      @(posedge clock);
      t++;
    end
    repeat (3) @(posedge clock);
    #1;
    check({name, "_pending"}, exp_q.size(), 0);
  endtask

  // Consumer: random pop pressure, gated by cons_en.
  initial forever begin
    @(posedge clock); #1;
    out_rd_en = cons_en && ($urandom_range(0, 3) != 0);
  end

  // Monitor: every accepted pop is compared with the scoreboard head.
  initial forever begin
    @(negedge clock);
    if (!reset && out_rd_en && !out_empty) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out: got %0h expected no output",
                 {out_rd_sof, out_rd_eof, out_dout});
      end else begin
        mon_e = exp_q.pop_front();
        check("payload", {22'd0, out_rd_sof, out_rd_eof, out_dout}, {22'd0, mon_e});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit saw_empty, saw_full;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_out_empty", out_empty, 1);
    check("rst_in_full", in_full, 0);
    check("rst_out_dout", out_dout, 0);
    check("rst_sof_eof", {out_rd_sof, out_rd_eof}, 0);

    // 60 B frame, 10 payload bytes plus 8 padding
    build(16'h0800, 8'h45, 8'h11, 16'h0012, 18);
    check("t1_len", frm.size(), 60);
    send_frame(1);
    drain("t1");

    // Back-to-back: IPv4/UDP, ARP, IPv4/UDP
    build(16'h0800, 8'h45, 8'h11, 16'd20, 14); send_frame(1);
    build(16'h0806, 8'h45, 8'h11, 16'd20, 14); send_frame(1);
    build(16'h0800, 8'h45, 8'h11, 16'd17, 9);  send_frame(1);
    drain("t2");

    // TCP frame, then IHL=6 UDP frame with options
    build(16'h0800, 8'h45, 8'h06, 16'd20, 12); send_frame(1);
    build(16'h0800, 8'h46, 8'h11, 16'd30, 22); send_frame(1);
    drain("t3");

    // 200 B payload with a 100-cycle consumer hold
    build(16'h0800, 8'h45, 8'h11, 16'd208, 200);
    fork
      send_frame(1);
      begin
        repeat (70) @(posedge clock);
        #1;
        cons_en = 1'b0;
        repeat (10) @(negedge clock);
        saw_empty = 1'b0;
        saw_full  = 1'b0;
        repeat (90) begin
          @(negedge clock);
          if (out_empty) saw_empty = 1'b1;
          if (in_full) saw_full = 1'b1;
        end
        check("t4_hold_out_empty", saw_empty, 0);
        check("t4_hold_in_full", saw_full, 1);
        cons_en = 1'b1;
      end
    join
    drain("t4");

    // Truncated at payload byte 3 of L=20, then a normal frame
    build(16'h0800, 8'h45, 8'h11, 16'd20, 3);
    while (frm.size() > 45) void'(frm.pop_back());
    send_frame(1);
    build(16'h0800, 8'h45, 8'h11, 16'd24, 16); send_frame(1);
    drain("t5");

    // Reset mid-payload with the consumer parked
    cons_en = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    build(16'h0800, 8'h45, 8'h11, 16'd30, 22);
    for (int i = 0; i < 45; i++) send_byte(frm[i], i == 0, 1'b0);
    repeat (5) @(posedge clock);
    #1;
    check("t6_pre_out_empty", out_empty, 0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("t6_out_empty", out_empty, 1);
    check("t6_in_full", in_full, 0);
    cons_en = 1'b1;
    build(16'h0800, 8'h45, 8'h11, 16'd19, 11); send_frame(1);
    drain("t6");

    // Random mix of good, dropped and truncated frames
    for (int f = 0; f < 25; f++) begin
      logic [15:0] et;
      logic [7:0]  vi, pr;
      int          cut;
      et = ($urandom_range(0, 7) == 0) ? 16'h86dd : 16'h0800;
      vi = ($urandom_range(0, 7) == 0) ? 8'h44 : 8'h45 + 8'($urandom_range(0, 2));
      pr = ($urandom_range(0, 7) == 0) ? 8'h06 : 8'h11;
      build(et, vi, pr, 16'($urandom_range(0, 40)), $urandom_range(0, 40));
      if ($urandom_range(0, 5) == 0) begin
        cut = $urandom_range(1, frm.size());
        while (frm.size() > cut) void'(frm.pop_back());
      end
      send_frame(1);
    end
    drain("rand");
    check("end_out_empty", out_empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
